// File: rtl/clk_gate_ctrl.sv
// Per-unit clock-gating controller: gates each unit's clock after a run of idle
// cycles and restores it on request, acknowledging once the clock has settled.
module clk_gate_ctrl #(
   parameter int N_UNITS     = 4,
   parameter int IDLE_CYCLES = 8,
   parameter int WAKE_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               force_on,
   input  logic [N_UNITS-1:0] busy,
   input  logic [N_UNITS-1:0] wake_req,
   output logic [N_UNITS-1:0] gate_en,
   output logic [N_UNITS-1:0] wake_ack,
   output logic [N_UNITS-1:0] err,
   output logic               any_gated
);

   localparam int IW = $clog2(IDLE_CYCLES + 1);
   localparam int WW = $clog2(WAKE_CYCLES + 1);

   localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
   localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

   localparam logic [1:0] ST_ON   = 2'd0;
   localparam logic [1:0] ST_OFF  = 2'd1;
   localparam logic [1:0] ST_WAKE = 2'd2;

   logic [N_UNITS-1:0] gate_next;

   for (genvar i = 0; i < N_UNITS; i++) begin : g_unit
      logic [1:0]    state;
      logic [1:0]    state_next;
      logic [IW-1:0] idle_cnt;
      logic [IW-1:0] idle_next;
      logic [WW-1:0] wake_cnt;
      logic [WW-1:0] wake_next;
      logic          active;
      logic          gate_q;
      logic          ack_q;
      logic          err_q;

      // The wake condition out of OFF is the same as "active", so wake always
      // takes priority there; busy in OFF additionally flags an error.
      assign active = busy[i] | wake_req[i] | force_on;

      always_comb begin
         state_next = state;
         idle_next  = idle_cnt;
         wake_next  = wake_cnt;
         case (state)
            ST_ON: begin
               if (active) begin
                  idle_next = '0;
               end else if (idle_cnt == IDLE_LAST) begin
                  state_next = ST_OFF;
                  idle_next  = '0;
               end else begin
                  idle_next = idle_cnt + IW'(1);
               end
            end
            ST_OFF: begin
               idle_next = '0;
               wake_next = '0;
               if (active) begin
                  state_next = ST_WAKE;
               end
            end
            ST_WAKE: begin
               if (wake_cnt == WAKE_LAST) begin
                  state_next = ST_ON;
                  idle_next  = '0;
                  wake_next  = '0;
               end else begin
                  wake_next = wake_cnt + WW'(1);
               end
            end
            default: begin
               state_next = ST_ON;
               idle_next  = '0;
               wake_next  = '0;
            end
         endcase
      end

      // Outputs are registered from the next state so they line up with it.
      always_ff @(posedge clk) begin
         if (!rst) begin
            state    <= ST_ON;
            idle_cnt <= '0;
            wake_cnt <= '0;
            gate_q   <= 1'b1;
            ack_q    <= 1'b1;
            err_q    <= 1'b0;
         end else begin
            state    <= state_next;
            idle_cnt <= idle_next;
            wake_cnt <= wake_next;
            gate_q   <= (state_next != ST_OFF);
            ack_q    <= (state_next == ST_ON);
            err_q    <= err_q | ((state == ST_OFF) & busy[i]);
         end
      end

      assign gate_next[i] = (state_next != ST_OFF);
      assign gate_en[i]   = gate_q;
      assign wake_ack[i]  = ack_q;
      assign err[i]       = err_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         any_gated <= 1'b0;
      end else begin
         any_gated <= ~(&gate_next);
      end
   end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed testbench for clk_gate_ctrl with default parameters
// (4 units, 8 idle cycles, 2 wake cycles).
module tb_clk_gate_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       force_on;
   logic [3:0] busy;
   logic [3:0] wake_req;
   logic [3:0] gate_en;
   logic [3:0] wake_ack;
   logic [3:0] err;
   logic       any_gated;

   int check_cnt = 0;
   int pass_cnt  = 0;

   clk_gate_ctrl #(
      .N_UNITS(4),
      .IDLE_CYCLES(8),
      .WAKE_CYCLES(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .force_on(force_on),
      .busy(busy),
      .wake_req(wake_req),
      .gate_en(gate_en),
      .wake_ack(wake_ack),
      .err(err),
      .any_gated(any_gated)
   );

   always #5 clk = ~clk;

   // Drive one cycle's inputs, then let the edge ending that cycle pass.
   task automatic applyStimulus(input logic r, input logic f, input logic [3:0] b, input logic [3:0] w);
      rst      = r;
      force_on = f;
      busy     = b;
      wake_req = w;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_cnt++;
      if (observed === expected) begin
         pass_cnt++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Reset for one edge, then idle for eight edges so every unit is OFF.
   task automatic gateAll();
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
      end
      checkOutput("gateall_gate", gate_en, 4'h0);
   endtask

   initial begin
      rst      = 1'b0;
      force_on = 1'b0;
      busy     = 4'h0;
      wake_req = 4'h0;

      // Reset held three cycles with random inputs
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'($urandom), 4'($urandom), 4'($urandom));
         checkOutput("reset_gate", gate_en, 4'hF);
         checkOutput("reset_ack", wake_ack, 4'hF);
         checkOutput("reset_err", err, 4'h0);
         checkOutput("reset_any", any_gated, 1'b0);
      end

      // Idle gating, with busy[2] pulsed in idle cycle 7
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(1'b1, 1'b0, (k == 7) ? 4'h4 : 4'h0, 4'h0);
         if (k < 8) begin
            checkOutput("idle_gate_pre", gate_en, 4'hF);
            checkOutput("idle_any_pre", any_gated, 1'b0);
         end
      end
      checkOutput("idle_gate_8", gate_en, 4'h4);
      checkOutput("idle_ack_8", wake_ack, 4'h4);
      checkOutput("idle_any_8", any_gated, 1'b1);
      for (int k = 9; k <= 14; k++) begin
         applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
      end
      checkOutput("unit2_gate_14", gate_en, 4'h4);
      applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
      checkOutput("unit2_gate_15", gate_en, 4'h0);
      checkOutput("err_clean", err, 4'h0);

      // Wake handshake on unit 1 with wake_req held
      applyStimulus(1'b1, 1'b0, 4'h0, 4'h2);
      checkOutput("wake_gate_t1", gate_en, 4'h2);
      checkOutput("wake_ack_t1", wake_ack, 4'h0);
      applyStimulus(1'b1, 1'b0, 4'h0, 4'h2);
      checkOutput("wake_ack_t2", wake_ack, 4'h0);
      applyStimulus(1'b1, 1'b0, 4'h0, 4'h2);
      checkOutput("wake_ack_t3", wake_ack, 4'h2);
      checkOutput("wake_any_t3", any_gated, 1'b1);

      // Wake on unit 1 with wake_req dropped after one cycle
      gateAll();
      applyStimulus(1'b1, 1'b0, 4'h0, 4'h2);
      checkOutput("drop_gate_t1", gate_en, 4'h2);
      applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
      checkOutput("drop_ack_t2", wake_ack, 4'h0);
      applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
      checkOutput("drop_ack_t3", wake_ack, 4'h2);

      // wake_req[0] at idle count 7 keeps unit 0 on
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
      for (int k = 1; k <= 7; k++) begin
         applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
      end
      applyStimulus(1'b1, 1'b0, 4'h0, 4'h1);
      checkOutput("simul_gate", gate_en, 4'h1);
      checkOutput("simul_ack", wake_ack, 4'h1);

      // force_on while units 1..3 are OFF
      applyStimulus(1'b1, 1'b1, 4'h0, 4'h0);
      checkOutput("force_gate_t1", gate_en, 4'hF);
      checkOutput("force_ack_t1", wake_ack, 4'h1);
      checkOutput("force_any_t1", any_gated, 1'b0);
      applyStimulus(1'b1, 1'b1, 4'h0, 4'h0);
      checkOutput("force_ack_t2", wake_ack, 4'h1);
      applyStimulus(1'b1, 1'b1, 4'h0, 4'h0);
      checkOutput("force_ack_t3", wake_ack, 4'hF);
      for (int k = 0; k < 12; k++) begin
         applyStimulus(1'b1, 1'b1, 4'h0, 4'h0);
      end
      checkOutput("force_hold_gate", gate_en, 4'hF);
      checkOutput("force_hold_any", any_gated, 1'b0);

      // busy[3] while unit 3 is OFF
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
      end
      checkOutput("err_pre_gate", gate_en, 4'h0);
      applyStimulus(1'b1, 1'b0, 4'h8, 4'h0);
      checkOutput("err_set", err, 4'h8);
      checkOutput("err_gate_t1", gate_en, 4'h8);
      applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
      applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
      checkOutput("err_wake_ack", wake_ack, 4'h8);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
      end
      checkOutput("err_sticky", err, 4'h8);
      checkOutput("err_regated", gate_en, 4'h0);
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
      checkOutput("err_cleared", err, 4'h0);

      // Reset during the first WAKE cycle of unit 2
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
      end
      applyStimulus(1'b1, 1'b0, 4'h0, 4'h4);
      checkOutput("rstwake_gate_t1", gate_en, 4'h4);
      checkOutput("rstwake_ack_t1", wake_ack, 4'h0);
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h4);
      checkOutput("rstwake_gate", gate_en, 4'hF);
      checkOutput("rstwake_ack", wake_ack, 4'hF);
      checkOutput("rstwake_any", any_gated, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
      applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
      checkOutput("rstwake_ack_after", wake_ack, 4'hF);

      $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/clk_gate_ctrl.md
# clk_gate_ctrl

Per-unit clock-gating controller that produces the `enable` inputs for the processor's latched clock-gate cells. It watches each gated unit's activity and wake requests. After a programmable run of idle cycles it switches the unit's clock off. On request it switches the clock back on and signals when the unit is usable again. It sits between the pipeline control logic and the bank of clock-gate cells, on the ungated core clock.

## Interface
- `N_UNITS`, default 4: number of independently gated units; must be ≥ 1.
- `IDLE_CYCLES`, default 8: consecutive idle cycles before gating; must be ≥ 1.
- `WAKE_CYCLES`, default 2: settle cycles between clock restore and ack; must be ≥ 1.

- `clk`  in  1  core clock, ungated.
- `rst`  in  1  reset, synchronous, active-low.
- `force_on`  in  1  global override: when high, every unit wakes and none may gate.
- `busy`  in  N_UNITS  per-unit activity indicator; high = unit doing work this cycle.
- `wake_req`  in  N_UNITS  per-unit request to use the unit; held high until `wake_ack`.
- `gate_en`  out  N_UNITS  registered clock enable to the clock-gate cell; 1 = clock runs.
- `wake_ack`  out  N_UNITS  registered; 1 = unit clock running and settled (state ON).
- `err`  out  N_UNITS  sticky: `busy` seen high while the unit was OFF.
- `any_gated`  out  1  registered OR of ~`gate_en`.

## Operation
- There is one independent FSM per unit, with states ON, OFF and WAKE. Each FSM has an idle counter of width clog2(IDLE_CYCLES+1) and a wake counter of width clog2(WAKE_CYCLES+1).
- A unit is *active* in a cycle when `busy[i]` | `wake_req[i]` | `force_on` is high.
- **ON:** `gate_en`=1, `wake_ack`=1.
  - If the unit is active, the idle counter clears to 0.
  - Otherwise the idle counter increments.
  - If the unit is idle and the counter equals IDLE_CYCLES-1, the next state is OFF and the counter clears.
- **OFF:** `gate_en`=0, `wake_ack`=0, and both counters are held at 0.
  - If `wake_req[i]` | `force_on` | `busy[i]`, the next state is WAKE.
  - `busy[i]` in OFF also sets `err[i]`. It stays set until reset.
- **WAKE:** `gate_en`=1, `wake_ack`=0. The wake counter increments each cycle.
  - When the counter equals WAKE_CYCLES-1, the next state is ON, with the idle counter and wake counter both 0.
  - Dropping `wake_req` during WAKE does not abort; the wake always completes to ON.
- **Simultaneous events:**
  - In ON, an active cycle always beats the idle threshold: there is no gating on that cycle.
  - In OFF, wake has priority over everything.
  - `force_on` high keeps ON units in ON (the counter keeps clearing) and drives OFF units through WAKE.
- The units never interact; `any_gated` is the only shared output.

## Timing
- **Reset** (`rst`=0 at a rising edge): all FSMs go to ON, all counters to 0.
  - Outputs after that edge: `gate_en`=all 1s, `wake_ack`=all 1s, `err`=0, `any_gated`=0.
  - Reset applied mid-WAKE or in OFF also forces ON, with the clock enabled, on the next edge.
- **Gating latency:** if the last active cycle is t, `gate_en[i]` falls after the edge ending cycle t+IDLE_CYCLES. `any_gated` rises on that same edge.
- **Wake latency from OFF:** if `wake_req` is first high in cycle t:
  - `gate_en` rises after the edge ending cycle t.
  - `wake_ack` rises after the edge ending cycle t+WAKE_CYCLES.
  - Total latency is WAKE_CYCLES+1 cycles.
- **Wake while ON:** `wake_ack` is already 1, so the latency is zero.
- **Handshake:**
  - The requester holds `wake_req` until it samples `wake_ack`=1.
  - The requester may use the unit in the same cycle it samples the ack.
  - `wake_ack` never falls while `wake_req` is high.
- **Glitch-free:** all outputs come straight from rising-edge flops. `gate_en` is therefore stable across the falling-edge capture in the gate cell.
- **Minimum OFF dwell:** 1 cycle. With IDLE_CYCLES=1, a single idle cycle gates the unit.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with random inputs, then release.
  - Required: `gate_en`=4'hF, `wake_ack`=4'hF, `err`=0 and `any_gated`=0 on the first edge after reset is applied and on every cycle after release until the idle threshold.
- **Idle gating:** IDLE_CYCLES=8; all inputs 0 from cycle 0.
  - Required: `gate_en` goes 1→0 exactly after the 8th idle edge, and `any_gated` goes to 1 on the same edge.
  - With `busy[2]` pulsed at idle cycle 7, unit 2 gates 8 cycles after the pulse instead.
- **Wake handshake:** WAKE_CYCLES=2, unit 1 OFF; `wake_req[1]` rises in cycle t and is held.
  - Required: `gate_en[1]`=1 from t+1, and `wake_ack[1]`=1 from t+3.
  - With `wake_req[1]` dropped at t+1, the ack still arrives at t+3.
- **Simultaneous events:**
  - Unit 0 at idle count 7 with `wake_req[0]` high that cycle: unit 0 stays ON.
  - `force_on` raised while units 1 and 3 are OFF: both reach ON after 3 cycles, and none gate while `force_on` stays high.
- **Error flag:** `busy[3]`=1 while unit 3 is OFF.
  - Required: `err[3]`=1 next cycle, unit 3 wakes normally, and `err[3]` stays 1 until `rst`=0.
- **Reset mid-wake:** assert `rst`=0 during WAKE cycle 1.
  - Required: `gate_en`=1 and `wake_ack`=1 on the next edge, and the wake counter is cleared.
